mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shared-bus arbiter for instruction-fetch and data ports with anti-starvation,
// wait timeout and fetch cancel. All outputs except the stalls are registered.
//
// state      | meaning
// S_IDLE     | no transaction in flight, arbitration happens here
// S_IF_BUSY  | bus owned by the fetch port, waiting for bus_ready
// S_MEM_BUSY | bus owned by the data port, waiting for bus_ready
module mem_bus_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int SW = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_TOP   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_IF_BUSY, S_MEM_BUSY} state_t;

  state_t        state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic [3:0]    bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          mem_ack_q, mem_ack_d;
  logic          bus_err_q, bus_err_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          cancel_q, cancel_d;

  logic if_elig, mem_elig, starved, grant_if, grant_mem;
  logic busy, done_ok, done_to, finish, fetch_dead;
  logic [31:0] done_data;

  always_comb begin
    if_elig    = if_req & ~if_ack_q & ~if_cancel;
    mem_elig   = mem_req & ~mem_ack_q;
    starved    = (starve_q == STARVE_TOP);
    grant_if   = (state_q == S_IDLE) & if_elig & (~mem_elig | starved);
    grant_mem  = (state_q == S_IDLE) & mem_elig & ~grant_if;
    busy       = (state_q != S_IDLE);
    done_ok    = busy & bus_ready;
    done_to    = busy & ~bus_ready & (wait_q == WAIT_TOP);
    finish     = done_ok | done_to;
    // a cancel seen in the completing cycle still kills the fetch
    fetch_dead = cancel_q | if_cancel;
    done_data  = done_ok ? bus_rdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_if)       state_d = S_IF_BUSY;
        else if (grant_mem) state_d = S_MEM_BUSY;
      end
      S_IF_BUSY, S_MEM_BUSY: begin
        if (finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    bus_err_d   = 1'b0;
    starve_d    = starve_q;
    wait_d      = wait_q;
    cancel_d    = cancel_q;
    unique case (state_q)
      S_IDLE: begin
        wait_d   = '0;
        cancel_d = 1'b0;
        if (grant_if) begin
          bus_req_d   = 1'b1;
          bus_addr_d  = if_addr;
          bus_we_d    = 4'h0;
          bus_wdata_d = 32'h0;
        end else if (grant_mem) begin
          bus_req_d   = 1'b1;
          bus_addr_d  = mem_addr;
          bus_we_d    = mem_we;
          bus_wdata_d = mem_wdata;
        end
        if (!if_req)                  starve_d = '0;
        else if (grant_if)            starve_d = '0;
        else if (grant_mem && !starved) starve_d = starve_q + SW'(1);
      end
      S_IF_BUSY, S_MEM_BUSY: begin
        if (state_q == S_IF_BUSY && if_cancel) cancel_d = 1'b1;
        if (finish) begin
          bus_req_d = 1'b0;
          bus_err_d = done_to;
          if (state_q == S_MEM_BUSY) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = done_data;
          end else if (!fetch_dead) begin
            if_ack_d   = 1'b1;
            if_rdata_d = done_data;
          end
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      starve_q    <= '0;
      wait_q      <= '0;
      cancel_q    <= 1'b0;
    end else begin
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      bus_err_q   <= bus_err_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      cancel_q    <= cancel_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign bus_err   = bus_err_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT    = 16;
  localparam int STARVE_MAX = 2;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        if_req = 1'b0, if_cancel = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_req = 1'b0;
  logic [3:0]  mem_we = '0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_we;
  logic        if_ack, mem_ack, bus_req, stall_if, stall_mem, bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .clrn(clrn),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // transaction-level view: who owns the bus, how long it has waited,
  // whether the fetch was flushed, and how many data grants jumped a waiting fetch
  int          owner;   // 0 none, 1 fetch, 2 data
  int          age;
  bit          flushed;
  int          streak;
  logic        e_bus_req, e_if_ack, e_mem_ack, e_err;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wdata, e_if_rd, e_mem_rd;

  task automatic model_step();
    bit want_if, want_mem;
    logic [31:0] data;
    if (!clrn) begin
      owner = 0; age = 0; flushed = 0; streak = 0;
      e_bus_req = 0; e_if_ack = 0; e_mem_ack = 0; e_err = 0;
      e_we = '0; e_addr = '0; e_wdata = '0; e_if_rd = '0; e_mem_rd = '0;
      return;
    end
    want_if  = if_req && !e_if_ack && !if_cancel;
    want_mem = mem_req && !e_mem_ack;
    e_if_ack = 0; e_mem_ack = 0; e_err = 0;
    if (owner == 0) begin
      if (want_if && (!want_mem || streak == STARVE_MAX)) begin
        owner = 1; e_addr = if_addr; e_we = '0; e_wdata = '0; streak = 0;
      end else if (want_mem) begin
        owner = 2; e_addr = mem_addr; e_we = mem_we; e_wdata = mem_wdata;
        streak = if_req ? ((streak < STARVE_MAX) ? streak + 1 : STARVE_MAX) : 0;
      end else if (!if_req) begin
        streak = 0;
      end
      e_bus_req = (owner != 0);
      age = 0;
      flushed = 0;
    end else begin
      if (owner == 1 && if_cancel) flushed = 1;
      if (bus_ready || age == TIMEOUT - 1) begin
        data  = bus_ready ? bus_rdata : 32'h0;
        e_err = !bus_ready;
        if (owner == 2) begin
          e_mem_ack = 1; e_mem_rd = data;
        end else if (!flushed) begin
          e_if_ack = 1; e_if_rd = data;
        end
        owner = 0;
        e_bus_req = 0;
      end else begin
        age++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("bus_req", bus_req, e_bus_req);
    chk("bus_we", bus_we, e_we);
    chk("bus_addr", bus_addr, e_addr);
    chk("bus_wdata", bus_wdata, e_wdata);
    chk("if_ack", if_ack, e_if_ack);
    chk("if_rdata", if_rdata, e_if_rd);
    chk("mem_ack", mem_ack, e_mem_ack);
    chk("mem_rdata", mem_rdata, e_mem_rd);
    chk("bus_err", bus_err, e_err);
    chk("stall_if", stall_if, if_req & ~e_if_ack);
    chk("stall_mem", stall_mem, mem_req & ~e_mem_ack);
  endtask

  initial begin
    int n;
    owner = 0; age = 0; flushed = 0; streak = 0;
    e_bus_req = 0; e_if_ack = 0; e_mem_ack = 0; e_err = 0;
    e_we = '0; e_addr = '0; e_wdata = '0; e_if_rd = '0; e_mem_rd = '0;
    @(negedge clk);
    clrn = 0; tick(); tick();
    chk("rst_bus_req", bus_req, 0);
    clrn = 1;

    // single fetch, ready in first BUSY cycle
    if_req = 1; if_addr = 32'h0040_0000; bus_ready = 1; bus_rdata = 32'h8C02_0004;
    tick();
    chk("fetch_grant_req", bus_req, 1);
    chk("fetch_grant_we", bus_we, 4'h0);
    tick();
    chk("fetch_ack", if_ack, 1);
    chk("fetch_rdata", if_rdata, 32'h8C02_0004);
    if_req = 0;
    tick();
    chk("fetch_ack_pulse", if_ack, 0);

    // simultaneous requests: data first, fetch granted in the data ack cycle
    mem_req = 1; mem_we = 4'hF; mem_addr = 32'h1001_0000; mem_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h0040_0000;
    tick();
    chk("both_first_we", bus_we, 4'hF);
    chk("both_first_addr", bus_addr, 32'h1001_0000);
    tick();
    chk("both_mem_ack", mem_ack, 1);
    mem_req = 0;
    tick();
    chk("both_if_grant", bus_addr, 32'h0040_0000);
    chk("both_if_we", bus_we, 4'h0);
    tick();
    chk("both_if_ack", if_ack, 1);
    if_req = 0;
    tick();

    // timeout on a data read
    bus_ready = 0; mem_req = 1; mem_we = 4'h0; mem_addr = 32'h1001_0040;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); n++;
      if (mem_ack) break;
    end
    chk("timeout_cycles", n, 17);
    chk("timeout_rdata", mem_rdata, 32'h0);
    chk("timeout_err", bus_err, 1);
    mem_req = 0;
    tick();
    chk("timeout_err_pulse", bus_err, 0);

    // cancel during a fetch: bus still completes, no ack, data untouched
    if_req = 1; if_addr = 32'h0040_0010; bus_rdata = 32'h1111_2222;
    tick();
    if_cancel = 1; tick();
    if_cancel = 0; tick();
    bus_ready = 1; tick();
    chk("cancel_bus_done", bus_req, 0);
    chk("cancel_no_ack", if_ack, 0);
    chk("cancel_rdata_kept", if_rdata, 32'h8C02_0004);
    tick();
    chk("cancel_regrant", bus_addr, 32'h0040_0010);
    tick();
    chk("cancel_next_ack", if_ack, 1);
    chk("cancel_next_rdata", if_rdata, 32'h1111_2222);
    if_req = 0;
    tick();

    // reset while the data port owns the bus
    mem_req = 1; mem_we = 4'h3; mem_addr = 32'h1001_0080; bus_ready = 0;
    tick(); tick();
    clrn = 0; tick();
    chk("rst_mid_req", bus_req, 0);
    chk("rst_mid_addr", bus_addr, 32'h0);
    chk("rst_mid_if_rdata", if_rdata, 32'h0);
    clrn = 1; mem_req = 0; bus_ready = 1;
    tick();
    chk("rst_mid_no_ack", mem_ack, 0);

    // data port hogging while fetch is flushed, then fetch released
    if_req = 1; if_addr = 32'h0040_0100; if_cancel = 1;
    mem_req = 1; mem_we = 4'hF; mem_addr = 32'h1001_0100; bus_ready = 1;
    for (int i = 0; i < 7; i++) tick();
    if_cancel = 0;
    for (int i = 0; i < 8; i++) tick();
    if_req = 0; mem_req = 0;
    tick(); tick();

    // random traffic
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (if_req && if_ack) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (mem_req && mem_ack) begin
        mem_req = 1'($urandom_range(0, 1)); mem_addr = $urandom; mem_wdata = $urandom;
        mem_we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      end else if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req = 1; mem_addr = $urandom; mem_wdata = $urandom;
        mem_we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      end
      if_cancel = ($urandom_range(0, 11) == 0);
      bus_ready = ((cyc % 600) < 120) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 0);
      bus_rdata = $urandom;
      clrn = ($urandom_range(0, 249) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
